// File: rtl/leds_pwm_pkg.sv
// Shared types, register map and helpers for the multi-LED AXI4-Lite peripheral.
package leds_pwm_pkg;

   typedef enum logic [1:0] {
      LedOff   = 2'b00,
      LedOn    = 2'b01,
      LedBlink = 2'b10,
      LedPwm   = 2'b11
   } led_mode_t;

   // Byte offsets of the registers.
   localparam int unsigned RegCtrl      = 'h00;
   localparam int unsigned RegMode      = 'h04;
   localparam int unsigned RegPrescale  = 'h08;
   localparam int unsigned RegBlinkHalf = 'h0C;
   localparam int unsigned RegStatus    = 'h10;
   localparam int unsigned RegDutyBase  = 'h20;

   localparam logic [1:0] RespOkay = 2'b00;

   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/leds_pwm_timebase.sv
// Shared prescaler, blink and PWM counters; all held at zero while disabled.
module leds_pwm_timebase #(
   parameter int unsigned PrescaleBits = 16,
   parameter int unsigned PwmBits      = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_en,
   input  logic [PrescaleBits-1:0] i_prescale,
   input  logic [15:0]             i_blink_half,
   input  logic                    i_prescale_clr,
   input  logic                    i_blink_clr,
   output logic                    o_tick,
   output logic                    o_blink_phase,
   output logic [PwmBits-1:0]      o_pwm_cnt
);

   // PWM counter wraps after 2^B-2 so a duty of 2^B-1 means always on.
   localparam logic [PwmBits-1:0] PwmMax = {{(PwmBits-1){1'b1}}, 1'b0};

   logic [PrescaleBits-1:0] r_pre_cnt;
   logic [15:0]             r_blink_cnt;
   logic                    r_blink_phase;
   logic [PwmBits-1:0]      r_pwm_cnt;
   logic                    w_tick;

   assign w_tick = i_en && (r_pre_cnt == i_prescale);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pre_cnt     <= '0;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
         r_pwm_cnt     <= '0;
      end else if (!i_en) begin
         r_pre_cnt     <= '0;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
         r_pwm_cnt     <= '0;
      end else begin
         if (i_prescale_clr || w_tick) r_pre_cnt <= '0;
         else                          r_pre_cnt <= r_pre_cnt + PrescaleBits'(1);

         if (i_blink_clr) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
         end else if (w_tick) begin
            if (r_blink_cnt == i_blink_half) begin
               r_blink_cnt   <= '0;
               r_blink_phase <= ~r_blink_phase;
            end else begin
               r_blink_cnt <= r_blink_cnt + 16'd1;
            end
         end

         if (w_tick) begin
            if (r_pwm_cnt == PwmMax) r_pwm_cnt <= '0;
            else                     r_pwm_cnt <= r_pwm_cnt + PwmBits'(1);
         end
      end
   end

   assign o_tick        = w_tick;
   assign o_blink_phase = r_blink_phase;
   assign o_pwm_cnt     = r_pwm_cnt;

endmodule

// File: rtl/leds_pwm_axi.sv
// AXI4-Lite slave with per-LED off/on/blink/PWM modes driven from a shared timebase.
module leds_pwm_axi #(
   parameter int unsigned C_NUM_OF_LEDS        = 4,
   parameter int unsigned C_S00_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S00_AXI_ADDR_WIDTH = 6,
   parameter int unsigned C_PWM_BITS           = 8,
   parameter int unsigned C_PRESCALE_BITS      = 16
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_areset,
   output logic [C_NUM_OF_LEDS-1:0]          leds,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]                        s00_axi_awprot,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,
   input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,
   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]                        s00_axi_arprot,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,
   output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready
);

   import leds_pwm_pkg::*;

   localparam int unsigned N  = C_NUM_OF_LEDS;
   localparam int unsigned AW = C_S00_AXI_ADDR_WIDTH - 2;

   localparam logic [AW-1:0] WCtrl      = AW'(RegCtrl / 4);
   localparam logic [AW-1:0] WMode      = AW'(RegMode / 4);
   localparam logic [AW-1:0] WPrescale  = AW'(RegPrescale / 4);
   localparam logic [AW-1:0] WBlinkHalf = AW'(RegBlinkHalf / 4);
   localparam logic [AW-1:0] WStatus    = AW'(RegStatus / 4);

   logic                       r_awready, r_wready, r_bvalid;
   logic                       r_arready, r_rvalid;
   logic [AW-1:0]              r_araddr;
   logic [31:0]                r_rdata;
   logic                       r_en;
   logic [2*N-1:0]             r_mode;
   logic [C_PRESCALE_BITS-1:0] r_prescale;
   logic [15:0]                r_blink_half;
   logic [C_PWM_BITS-1:0]      r_duty [N];
   logic [N-1:0]               r_leds;

   logic                       w_wren;
   logic [AW-1:0]              w_waddr;
   logic [31:0]                w_wr_merged;
   logic [31:0]                w_regs [2**AW];
   logic [N-1:0]               w_led_next;
   logic                       w_tick, w_blink_phase;
   logic [C_PWM_BITS-1:0]      w_pwm_cnt;
   logic                       w_unused;

   // Handshake completes on the edge after awready/wready were raised.
   assign w_wren  = r_awready && s00_axi_awvalid && s00_axi_wvalid;
   assign w_waddr = s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2];

   always_comb begin
      for (int i = 0; i < 2**AW; i++) w_regs[i] = '0;
      w_regs[WCtrl]      = {31'b0, r_en};
      w_regs[WMode]      = 32'(r_mode);
      w_regs[WPrescale]  = 32'(r_prescale);
      w_regs[WBlinkHalf] = {16'b0, r_blink_half};
      w_regs[WStatus]    = 32'(r_leds);
      for (int i = 0; i < N; i++) w_regs[AW'(RegDutyBase / 4 + i)] = 32'(r_duty[i]);
   end

   assign w_wr_merged = apply_wstrb(w_regs[w_waddr], s00_axi_wdata, s00_axi_wstrb);

   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
      end else begin
         if (s00_axi_awvalid && s00_axi_wvalid && !r_awready && !r_bvalid) begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
         end else begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
         end
         if (w_wren)                          r_bvalid <= 1'b1;
         else if (r_bvalid && s00_axi_bready) r_bvalid <= 1'b0;
      end
   end

   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         r_en         <= 1'b0;
         r_mode       <= '0;
         r_prescale   <= '0;
         r_blink_half <= '0;
         for (int i = 0; i < N; i++) r_duty[i] <= '0;
      end else if (w_wren) begin
         if (w_waddr == WCtrl)      r_en         <= w_wr_merged[0];
         if (w_waddr == WMode)      r_mode       <= w_wr_merged[2*N-1:0];
         if (w_waddr == WPrescale)  r_prescale   <= w_wr_merged[C_PRESCALE_BITS-1:0];
         if (w_waddr == WBlinkHalf) r_blink_half <= w_wr_merged[15:0];
         for (int i = 0; i < N; i++) begin
            if (w_waddr == AW'(RegDutyBase / 4 + i)) r_duty[i] <= w_wr_merged[C_PWM_BITS-1:0];
         end
      end
   end

   // rdata is only loaded from the accept cycle, so it stays stable while rvalid waits.
   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         r_arready <= 1'b0;
         r_araddr  <= '0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
      end else begin
         if (s00_axi_arvalid && !r_arready && !r_rvalid) begin
            r_arready <= 1'b1;
            r_araddr  <= s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2];
         end else begin
            r_arready <= 1'b0;
         end
         if (r_arready) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_regs[r_araddr];
         end else if (r_rvalid && s00_axi_rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   leds_pwm_timebase #(
      .PrescaleBits (C_PRESCALE_BITS),
      .PwmBits      (C_PWM_BITS)
   ) u_timebase (
      .i_clk          (s00_axi_aclk),
      .i_rst          (s00_axi_areset),
      .i_en           (r_en),
      .i_prescale     (r_prescale),
      .i_blink_half   (r_blink_half),
      .i_prescale_clr (w_wren && (w_waddr == WPrescale)),
      .i_blink_clr    (w_wren && (w_waddr == WBlinkHalf)),
      .o_tick         (w_tick),
      .o_blink_phase  (w_blink_phase),
      .o_pwm_cnt      (w_pwm_cnt)
   );

   always_comb begin
      w_led_next = '0;
      for (int i = 0; i < N; i++) begin
         unique case (led_mode_t'(r_mode[2*i +: 2]))
            LedOff:   w_led_next[i] = 1'b0;
            LedOn:    w_led_next[i] = 1'b1;
            LedBlink: w_led_next[i] = w_blink_phase;
            LedPwm:   w_led_next[i] = (w_pwm_cnt < r_duty[i]);
         endcase
      end
   end

   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) r_leds <= '0;
      else                r_leds <= r_en ? w_led_next : '0;
   end

   assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                       s00_axi_araddr[1:0], w_tick, w_wr_merged};

   assign leds            = r_leds;
   assign s00_axi_awready = r_awready;
   assign s00_axi_wready  = r_wready;
   assign s00_axi_bresp   = RespOkay;
   assign s00_axi_bvalid  = r_bvalid;
   assign s00_axi_arready = r_arready;
   assign s00_axi_rdata   = r_rdata;
   assign s00_axi_rresp   = RespOkay;
   assign s00_axi_rvalid  = r_rvalid;

endmodule

// File: tb/tb_leds_pwm_axi.sv
// Directed and randomized bench for leds_pwm_axi against a time-based LED model.
module tb_leds_pwm_axi;

   localparam int unsigned N = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [N-1:0] leds;
   logic [5:0]  awaddr = '0, araddr = '0;
   logic [2:0]  awprot = '0, arprot = '0;
   logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
   logic        arvalid = 0, arready, rvalid, rready = 0;
   logic [31:0] wdata = '0, rdata;
   logic [3:0]  wstrb = '0;
   logic [1:0]  bresp, rresp;

   int checks = 0;
   int errors = 0;
   logic [31:0] shadow [16];

   leds_pwm_axi dut (
      .s00_axi_aclk    (clk),
      .s00_axi_areset  (rst),
      .leds            (leds),
      .s00_axi_awaddr  (awaddr),
      .s00_axi_awprot  (awprot),
      .s00_axi_awvalid (awvalid),
      .s00_axi_awready (awready),
      .s00_axi_wdata   (wdata),
      .s00_axi_wstrb   (wstrb),
      .s00_axi_wvalid  (wvalid),
      .s00_axi_wready  (wready),
      .s00_axi_bresp   (bresp),
      .s00_axi_bvalid  (bvalid),
      .s00_axi_bready  (bready),
      .s00_axi_araddr  (araddr),
      .s00_axi_arprot  (arprot),
      .s00_axi_arvalid (arvalid),
      .s00_axi_arready (arready),
      .s00_axi_rdata   (rdata),
      .s00_axi_rresp   (rresp),
      .s00_axi_rvalid  (rvalid),
      .s00_axi_rready  (rready)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Register model: each word keeps only its implemented bits.
   function automatic logic [31:0] word_mask(input int w);
      if (w == 0)             return 32'h1;
      if (w == 1)             return 32'h0000_00FF;
      if (w == 2 || w == 3)   return 32'h0000_FFFF;
      if (w >= 8 && w < 8+N)  return 32'h0000_00FF;
      return 32'h0;
   endfunction

   task automatic model_write(input logic [5:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
      int w;
      logic [31:0] v;
      w = int'(addr[5:2]);
      v = shadow[w];
      for (int b = 0; b < 4; b++) if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
      shadow[w] = v & word_mask(w);
   endtask

   // Expected LEDs k clocks after the edge where EN went 1, from elapsed time alone.
   function automatic logic [N-1:0] model_leds(input int k);
      int j, t, phase, pcnt, m;
      logic [N-1:0] r;
      j = k - 1;
      t = j / (int'(shadow[2]) + 1);
      pcnt = t % 255;
      phase = (t / (int'(shadow[3]) + 1)) % 2;
      for (int i = 0; i < N; i++) begin
         m = int'((shadow[1] >> (2*i)) & 32'h3);
         case (m)
            0: r[i] = 1'b0;
            1: r[i] = 1'b1;
            2: r[i] = (phase == 1);
            default: r[i] = (pcnt < int'(shadow[8+i]));
         endcase
      end
      return r;
   endfunction

   // Returns on the falling edge after the register-update edge.
   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit hold_b);
      int n;
      @(negedge clk);
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1; wvalid = 1; bready = !hold_b;
      n = 0;
      while (!awready && n < 20) begin @(negedge clk); n++; end
      check("aw_accept", 32'(awready), 32'h1);
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      check("bvalid_up", 32'(bvalid), 32'h1);
      check("bresp", 32'(bresp), 32'h0);
      model_write(addr, data, strb);
   endtask

   task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, input bit hold_r);
      int n;
      @(negedge clk);
      araddr = addr; arvalid = 1; rready = !hold_r;
      n = 0;
      while (!arready && n < 20) begin @(negedge clk); n++; end
      check("ar_accept", 32'(arready), 32'h1);
      arvalid = 0;
      @(negedge clk);
      n = 0;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      check("rvalid_up", 32'(rvalid), 32'h1);
      data = rdata;
      resp = rresp;
   endtask

   task automatic run_model(input string tag, input int cycles);
      int bad;
      bad = 0;
      for (int k = 1; k <= cycles; k++) begin
         @(negedge clk);
         if (leds !== model_leds(k)) begin
            if (bad == 0) check({tag, "_trace"}, 32'(leds), 32'(model_leds(k)));
            bad++;
         end
      end
      check({tag, "_bad_cycles"}, 32'(bad), 32'h0);
   endtask

   initial begin
      logic [31:0] d, d2;
      logic [1:0]  r;
      int          cnt;
      bit          ok;

      for (int i = 0; i < 16; i++) shadow[i] = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_leds", 32'(leds), 32'h0);
      check("rst_ready_valid", {28'b0, awready, wready, bvalid, rvalid}, 32'h0);
      rst = 0;
      for (int a = 0; a < 16; a++) begin
         axi_read(6'(a * 4), d, r, 0);
         check($sformatf("rst_read_%0h", a * 4), d, 32'h0);
         check("rst_rresp", 32'(r), 32'h0);
      end

      // All on via MODE=0x55, visible two edges after the handshake edge
      axi_write(6'h00, 32'h1, 4'hF, 0);
      axi_write(6'h04, 32'h55, 4'hF, 0);
      check("on_latency_pre", 32'(leds), 32'h0);
      @(negedge clk);
      check("on_latency_post", 32'(leds), 32'hF);
      axi_read(6'h10, d, r, 0);
      check("status_on", d, 32'hF);
      axi_write(6'h04, 32'h00, 4'hF, 0);
      @(negedge clk);
      check("all_off", 32'(leds), 32'h0);

      // PWM duty 64/255 on LED0
      axi_write(6'h00, 32'h0, 4'hF, 0);
      axi_write(6'h08, 32'h0, 4'hF, 0);
      axi_write(6'h20, 32'd64, 4'hF, 0);
      axi_write(6'h04, 32'h03, 4'hF, 0);
      axi_write(6'h00, 32'h1, 4'hF, 0);
      cnt = 0;
      for (int k = 1; k <= 255; k++) begin
         @(negedge clk);
         if (leds !== model_leds(k)) check("pwm64_trace", 32'(leds), 32'(model_leds(k)));
         cnt += int'(leds[0]);
      end
      check("pwm64_high_count", 32'(cnt), 32'd64);
      axi_write(6'h20, 32'd0, 4'hF, 0);
      @(negedge clk);
      cnt = 0;
      for (int k = 0; k < 300; k++) begin @(negedge clk); cnt += int'(leds[0]); end
      check("pwm_duty0_highs", 32'(cnt), 32'd0);
      axi_write(6'h20, 32'd255, 4'hF, 0);
      @(negedge clk);
      cnt = 0;
      for (int k = 0; k < 300; k++) begin @(negedge clk); cnt += int'(leds[0]); end
      check("pwm_duty255_highs", 32'(cnt), 32'd300);

      // Blink: 50-clock half period, EN off/on restarts at phase 0
      axi_write(6'h00, 32'h0, 4'hF, 0);
      axi_write(6'h08, 32'd9, 4'hF, 0);
      axi_write(6'h0C, 32'd4, 4'hF, 0);
      axi_write(6'h04, 32'h02, 4'hF, 0);
      axi_write(6'h00, 32'h1, 4'hF, 0);
      run_model("blink", 220);
      axi_write(6'h00, 32'h0, 4'hF, 0);
      @(negedge clk);
      check("blink_en_off", 32'(leds), 32'h0);
      axi_write(6'h00, 32'h1, 4'hF, 0);
      run_model("blink_restart", 120);

      // Randomized modes/timing against the model
      for (int it = 0; it < 4; it++) begin
         axi_write(6'h00, 32'h0, 4'hF, 0);
         axi_write(6'h08, $urandom_range(0, 3), 4'hF, 0);
         axi_write(6'h0C, $urandom_range(0, 5), 4'hF, 0);
         axi_write(6'h04, $urandom_range(0, 255), 4'hF, 0);
         for (int i = 0; i < N; i++) axi_write(6'(32 + 4*i), $urandom_range(0, 255), 4'hF, 0);
         axi_write(6'h00, 32'h1, 4'hF, 0);
         run_model($sformatf("rand%0d", it), 200);
      end

      // Randomized register writes with byte strobes, then full readback (EN=0)
      axi_write(6'h00, 32'h0, 4'hF, 0);
      for (int it = 0; it < 12; it++) begin
         int w;
         w = int'($urandom_range(1, 15));
         axi_write(6'(w * 4), $urandom, 4'($urandom_range(0, 15)), 0);
      end
      for (int a = 0; a < 16; a++) begin
         axi_read(6'(a * 4), d, r, 0);
         check($sformatf("readback_%0h", a * 4), d, shadow[a]);
      end

      // Strobed MODE write and unmapped word
      axi_write(6'h04, 32'h0, 4'hF, 0);
      axi_write(6'h04, 32'hFFFF_FFFF, 4'b0001, 0);
      axi_read(6'h04, d, r, 0);
      check("mode_wstrb", d, 32'h0000_00FF);
      axi_write(6'h3C, 32'hFFFF_FFFF, 4'hF, 0);
      axi_read(6'h3C, d, r, 0);
      check("unmapped_read", d, 32'h0);
      axi_read(6'h04, d, r, 0);
      check("unmapped_no_effect", d, 32'h0000_00FF);

      // bvalid held by bready=0 blocks a second write
      axi_write(6'h04, 32'h11, 4'hF, 1);
      axi_read(6'h04, d, r, 0);
      check("held_write_applied", d, 32'h11);
      @(negedge clk);
      awaddr = 6'h04; wdata = 32'h22; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      ok = 1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (!bvalid || awready) ok = 0;
      end
      check("bvalid_hold_blocks", 32'(ok), 32'h1);
      bready = 1;
      cnt = 0;
      while (!awready && cnt < 20) begin @(negedge clk); cnt++; end
      check("second_write_accept", 32'(awready), 32'h1);
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      model_write(6'h04, 32'h22, 4'hF);
      axi_read(6'h04, d, r, 0);
      check("second_write_value", d, 32'h22);

      // rvalid held by rready=0 keeps rdata stable across a write
      axi_read(6'h04, d, r, 1);
      axi_write(6'h04, 32'h33, 4'hF, 0);
      ok = 1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (!rvalid || rdata !== 32'h22 || arready) ok = 0;
      end
      check("rvalid_hold_stable", 32'(ok), 32'h1);
      rready = 1;
      @(negedge clk);
      check("rvalid_drop", 32'(rvalid), 32'h0);

      // Simultaneous read and write of MODE returns the old value
      d2 = shadow[1];
      fork
         axi_write(6'h04, 32'h44, 4'hF, 0);
         axi_read(6'h04, d, r, 0);
      join
      check("rw_same_edge_old", d, d2);
      axi_read(6'h04, d, r, 0);
      check("rw_same_edge_new", d, 32'h44);

      // Reset while a write response is pending
      axi_write(6'h00, 32'h1, 4'hF, 1);
      #2;
      rst = 1;
      #1;
      check("rst_kills_bvalid", 32'(bvalid), 32'h0);
      @(negedge clk);
      rst = 0;
      bready = 1;
      for (int i = 0; i < 16; i++) shadow[i] = '0;
      axi_read(6'h00, d, r, 0);
      check("rst_ctrl_cleared", d, 32'h0);
      axi_read(6'h04, d, r, 0);
      check("rst_mode_cleared", d, 32'h0);
      check("rst_leds_after", 32'(leds), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/leds_pwm_axi.md
Name: leds_pwm_axi

Overview:
- Parametrised successor to the single-register AXI4-Lite LED peripheral.
- Drives C_NUM_OF_LEDS outputs; each LED has its own mode: off, on, blink or PWM dimming.
- Blink and PWM timing derive from a shared programmable prescaler.
- Sits as an AXI4-Lite slave on the PS/PL interconnect, same bus slot as the current LED block.

Parameters:
- C_NUM_OF_LEDS, 4, number of LED outputs, legal 1..8
- C_S00_AXI_DATA_WIDTH, 32, AXI data width, fixed 32
- C_S00_AXI_ADDR_WIDTH, 6, AXI byte address width (16 words)
- C_PWM_BITS, 8, PWM duty/counter width, legal 2..16
- C_PRESCALE_BITS, 16, prescaler width, legal 1..32

Ports:
- s00_axi_aclk  in  1  clock for bus and LED logic
- s00_axi_areset  in  1  asynchronous active-high reset
- leds  out  C_NUM_OF_LEDS  LED drive, registered
- s00_axi_awaddr/awprot/awvalid/awready  in/in/in/out  ADDR/3/1/1  write address channel; awprot ignored
- s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
- s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response
- s00_axi_araddr/arprot/arvalid/arready  in/in/in/out  ADDR/3/1/1  read address; arprot ignored
- s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data

Behaviour:
- Reset (async assert, sync release): all registers 0, leds=0, all ready/valid 0, bresp=rresp=2'b00. Reset mid-transaction aborts it with no response.
- Register map, word address = addr[ADDR-1:2]:
  - 0x00 CTRL: [0] EN.
  - 0x04 MODE: 2 bits per LED, LED i at [2i+1:2i]. 00 off, 01 on, 10 blink, 11 PWM.
  - 0x08 PRESCALE: [C_PRESCALE_BITS-1:0].
  - 0x0C BLINK_HALF: [15:0].
  - 0x10 STATUS: RO, [N-1:0] current leds.
  - 0x20+4i DUTY_i: [C_PWM_BITS-1:0], i<N.
  - Unmapped or unimplemented bits read 0; writes to them and to STATUS are ignored.
  - Response is always OKAY.
- Write channel:
  - awready and wready pulse together for one cycle when awvalid&&wvalid&&!awready&&!bvalid.
  - Register updates on that edge, byte lanes gated by wstrb.
  - bvalid rises the next cycle and holds until bready.
  - No new write is accepted while bvalid=1.
- Read channel:
  - arready pulses one cycle when arvalid&&!arready&&!rvalid; address latched.
  - rvalid rises the next cycle with rdata and holds (rdata stable) until rready.
- Read and write channels are independent. A read accepted on the same edge as a write to the same register returns the old value.
- Tick: prescaler counts 0..PRESCALE, tick=1 on the terminal count (PRESCALE=0 gives a tick every clock). A write to PRESCALE clears the counter.
- Blink:
  - Blink counter counts ticks 0..BLINK_HALF; blink_phase toggles on wrap.
  - Half-period = (BLINK_HALF+1)*(PRESCALE+1) clocks.
  - A write to BLINK_HALF clears the counter and phase.
- PWM:
  - Counter advances on tick, 0..2^B-2, then wraps to 0 (period 2^B-1 ticks).
  - pwm_i = cnt < DUTY_i. DUTY=0 gives always off; DUTY=2^B-1 gives always on.
- EN=0: prescaler, blink and PWM counters held at 0, phase 0, leds=0.
- leds registered from mode/counters. Visible change is 2 clocks after the write handshake edge (register, then output flop).
- LED i with i≥N: MODE bits and DUTY registers not implemented, read 0.

Decomposition:
- Package leds_pwm_pkg:
  - led_mode_t enum (OFF, ON, BLINK, PWM).
  - Register offset constants (CTRL, MODE, PRESCALE, BLINK_HALF, STATUS, DUTY_BASE).
  - Response codes RESP_OKAY.
- Sub-module leds_pwm_timebase: prescaler, blink and PWM counters; outputs tick, blink_phase, pwm_cnt. Shared by all channels.
- Top holds the AXI slave, register file and per-LED output mux.

Test Plan:
- Reset then read 0x00..0x3C → every rdata=0, rresp=00, leds=0. Assert reset during a pending bvalid → bvalid=0 immediately, registers 0.
- CTRL=1, MODE=0x55 (N=4) → leds=4'hF exactly 2 clocks after the write handshake; MODE=0x00 → leds=0. STATUS reads 0xF while on.
- PRESCALE=0, DUTY_0=64, MODE=0x03, EN=1, B=8 → led0 high exactly 64 of every 255 clocks. DUTY_0=0 → constantly 0; DUTY_0=255 → constantly 1.
- PRESCALE=9, BLINK_HALF=4, MODE=0x02, EN=1 → led0 toggles every 50 clocks. Clearing EN → led0=0 within 2 clocks; re-enable restarts at phase 0.
- MODE write 0xFFFFFFFF with wstrb=4'b0001 → MODE reads 0x000000FF. Write to 0x3C → OKAY, no effect. Read 0x3C → 0.
- Hold bready=0 after a write → bvalid stays 1; a second awvalid/wvalid is not accepted until bready is seen. Same check for rvalid with rready=0 (rdata stable). Simultaneous read and write to MODE → read returns the old value.
